// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : controller_pkg
//  Purpose  : Shared definitions for the shift/load sequencing controller.
//             These are the state encodings, the shift-count constant and
//             the state classification helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package controller_pkg;

   // The controller performs a fixed number of shift cycles.
   localparam int SHIFT_COUNT = 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'b000,
      S_LOAD = 3'b001,
      S_SH1  = 3'b010,
      S_SH2  = 3'b011,
      S_SH3  = 3'b100,
      S_SH4  = 3'b101,
      S_DONE = 3'b110
   } state_t;

   // The shift states are encoded contiguously, starting at S_SH1.
   // The last shift state follows from the shift count.
   localparam state_t S_LAST_SHIFT = state_t'(3'(int'(S_SH1) + SHIFT_COUNT - 1));

   function automatic logic is_shift_state(input state_t s);
      return (s >= S_SH1) && (s <= S_LAST_SHIFT);
   endfunction

   // These are the states in which a restart request may be honoured when
   // restart is enabled.
   function automatic logic is_restartable(input state_t s);
      return is_shift_state(s) || (s == S_DONE);
   endfunction

endpackage : controller_pkg
`default_nettype wire

// File: rtl/controller_decode.sv
`default_nettype none
// ============================================================================
//  Module   : controller_decode
//  Purpose  : Moore output decoder for the controller. It maps the current
//             state onto mutually exclusive datapath controls.
//  Ports    : state_i  current controller state (3 bits)
//             sh_o     shift enable, high in SH1..SH4
//             ld_o     parallel-load enable, high in LOAD
//             d_o      done flag, high in DONE
//  Revision : 1.0  initial release
// ============================================================================
module controller_decode
   import controller_pkg::*;
(
   input  state_t state_i,
   output logic   sh_o,
   output logic   ld_o,
   output logic   d_o
);

   // Each output decodes a disjoint set of codes, so the three outputs can
   // never be high together. The illegal code 111 matches none of them.
   always_comb begin
      sh_o = is_shift_state(state_i);
      ld_o = (state_i == S_LOAD);
      d_o  = (state_i == S_DONE);
   end

endmodule : controller_decode
`default_nettype wire

// File: rtl/controller.sv
`default_nettype none
// ============================================================================
//  Module   : controller
//  Purpose  : Sequencing controller for a shift register datapath. A start
//             request in IDLE produces one LOAD cycle, then SHIFT_COUNT shift
//             cycles, then one DONE cycle, and then a return to IDLE.
//  Ports    : Cin   clock, rising-edge active
//             RSTn  asynchronous active-low reset
//             ST    start request
//             SH    shift enable
//             LD    parallel-load enable
//             D     done flag
//  Config   : CONTROLLER_RESTART_EN - when defined, ST=1 sampled in any shift
//             state or in DONE restarts the sequence at LOAD.
//  Revision : 1.0  initial release
// ============================================================================
module controller
   import controller_pkg::*;
(
   input  logic Cin,
   input  logic RSTn,
   input  logic ST,
   output logic SH,
   output logic LD,
   output logic D
);

   // STATE keeps this exact name so that it can be reached by hierarchical
   // reference from outside the block.
   state_t STATE;
   state_t state_d;

   always_ff @(posedge Cin or negedge RSTn) begin
      if (!RSTn) begin
         STATE <= S_IDLE;
      end else begin
         STATE <= state_d;
      end
   end

   always_comb begin
      state_d = S_IDLE;
      case (STATE)
         S_IDLE:  state_d = ST ? S_LOAD : S_IDLE;
         S_LOAD:  state_d = S_SH1;
         S_SH1:   state_d = S_SH2;
         S_SH2:   state_d = S_SH3;
         S_SH3:   state_d = S_SH4;
         S_SH4:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         // Code 111 is illegal and recovers to IDLE.
         default: state_d = S_IDLE;
      endcase
`ifdef CONTROLLER_RESTART_EN
      // A new request during shifting or DONE abandons the current run.
      if (ST && is_restartable(STATE)) begin
         state_d = S_LOAD;
      end
`endif
   end

   controller_decode u_decode (
      .state_i (STATE),
      .sh_o    (SH),
      .ld_o    (LD),
      .d_o     (D)
   );

endmodule : controller
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controller
//  Purpose  : Directed self-checking bench for the controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_controller;
   import controller_pkg::*;

   logic Cin;
   logic RSTn;
   logic ST;
   logic SH;
   logic LD;
   logic D;

   int vectors;
   int errors;

   controller dut (
      .Cin  (Cin),
      .RSTn (RSTn),
      .ST   (ST),
      .SH   (SH),
      .LD   (LD),
      .D    (D)
   );

   initial Cin = 1'b0;
   always #5 Cin = ~Cin;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge Cin);
      #1;
   endtask

   task automatic test_reset();
      // RSTn is low from time 0 and no rising edge has occurred yet.
      vectors++;
      if (dut.STATE !== 3'b000) begin
         errors++;
         $display("FAIL reset_state: got %b expected 000", dut.STATE);
      end
      vectors++;
      if ({SH, LD, D} !== 3'b000) begin
         errors++;
         $display("FAIL reset_outputs: got SH/LD/D=%b expected 000", {SH, LD, D});
      end
   endtask

   task automatic test_idle_hold();
      ST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         vectors++;
         if (dut.STATE !== 3'b000 || {SH, LD, D} !== 3'b000) begin
            errors++;
            $display("FAIL idle_hold[%0d]: got state=%b SH/LD/D=%b expected 000/000",
                     i, dut.STATE, {SH, LD, D});
         end
      end
   endtask

   task automatic test_nominal();
      // Each entry is {state, SH, LD, D} after edges 1..8.
      logic [5:0] exp_tab [8];
      exp_tab[0] = 6'b001_010;
      exp_tab[1] = 6'b010_100;
      exp_tab[2] = 6'b011_100;
      exp_tab[3] = 6'b100_100;
      exp_tab[4] = 6'b101_100;
      exp_tab[5] = 6'b110_001;
      exp_tab[6] = 6'b000_000;
      exp_tab[7] = 6'b000_000;
      ST = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         ST = 1'b0;
         vectors++;
         if ({dut.STATE, SH, LD, D} !== exp_tab[i]) begin
            errors++;
            $display("FAIL nominal[edge %0d]: got state=%b SH/LD/D=%b expected %b/%b",
                     i + 1, dut.STATE, {SH, LD, D}, exp_tab[i][5:3], exp_tab[i][2:0]);
         end
      end
   endtask

   task automatic test_midrun_reset();
      bit saw_done;
      ST = 1'b1;
      step();
      ST = 1'b0;
      step();
      step();
      vectors++;
      if (dut.STATE !== 3'b011) begin
         errors++;
         $display("FAIL midrun_reach_sh2: got %b expected 011", dut.STATE);
      end
      // Assert reset between edges; the effect must be immediate.
      #2;
      RSTn = 1'b0;
      #1;
      vectors++;
      if (dut.STATE !== 3'b000 || {SH, LD, D} !== 3'b000) begin
         errors++;
         $display("FAIL midrun_async_reset: got state=%b SH/LD/D=%b expected 000/000",
                  dut.STATE, {SH, LD, D});
      end
      step();
      vectors++;
      if (dut.STATE !== 3'b000) begin
         errors++;
         $display("FAIL midrun_held_reset: got %b expected 000", dut.STATE);
      end
      #2;
      RSTn = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (D === 1'b1 || dut.STATE !== 3'b000) saw_done = 1'b1;
      end
      vectors++;
      if (saw_done) begin
         errors++;
         $display("FAIL midrun_no_done: got activity after abort, expected state 000 and no D");
      end
      ST = 1'b1;
      step();
      ST = 1'b0;
      vectors++;
      if (dut.STATE !== 3'b001 || LD !== 1'b1) begin
         errors++;
         $display("FAIL midrun_restart: got state=%b LD=%b expected 001/1", dut.STATE, LD);
      end
      for (int i = 0; i < 7; i++) step();
   endtask

   task automatic test_st_held();
      logic [2:0] exp_seq [9];
`ifdef CONTROLLER_RESTART_EN
      for (int i = 0; i < 9; i++) exp_seq[i] = (i % 2 == 0) ? 3'b001 : 3'b010;
`else
      exp_seq[0] = 3'b001;
      exp_seq[1] = 3'b010;
      exp_seq[2] = 3'b011;
      exp_seq[3] = 3'b100;
      exp_seq[4] = 3'b101;
      exp_seq[5] = 3'b110;
      exp_seq[6] = 3'b000;
      exp_seq[7] = 3'b001;
      exp_seq[8] = 3'b010;
`endif
      ST = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         vectors++;
         if (dut.STATE !== exp_seq[i]) begin
            errors++;
            $display("FAIL st_held[edge %0d]: got %b expected %b", i + 1, dut.STATE, exp_seq[i]);
         end
         vectors++;
         if ((SH + LD + D) > 1) begin
            errors++;
            $display("FAIL exclusive[edge %0d]: got SH/LD/D=%b expected at most one high",
                     i + 1, {SH, LD, D});
         end
      end
      ST = 1'b0;
      // Restore a clean IDLE before the next scenario.
      #2;
      RSTn = 1'b0;
      #2;
      RSTn = 1'b1;
   endtask

   task automatic test_illegal();
      ST = 1'b0;
      step();
      force dut.STATE = state_t'(3'b111);
      #1;
      vectors++;
      if ({SH, LD, D} !== 3'b000) begin
         errors++;
         $display("FAIL illegal_outputs: got SH/LD/D=%b expected 000", {SH, LD, D});
      end
      release dut.STATE;
      step();
      vectors++;
      if (dut.STATE !== 3'b000) begin
         errors++;
         $display("FAIL illegal_recover: got %b expected 000", dut.STATE);
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      RSTn    = 1'b0;
      ST      = 1'b0;
      #1;
      test_reset();
      #1;
      RSTn = 1'b1;
      test_idle_hold();
      test_nominal();
      test_midrun_reset();
      test_st_held();
      test_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule : tb_controller
`default_nettype wire
